// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
//   Takes bytes from a UART receiver one at a time, using the rx_rdy / clr_rdy
//   handshake, and builds 3-byte command frames from them: one opcode byte,
//   then two data bytes with the MSB first. A complete frame is held on
//   opcode/data with frm_vld until the decoder acknowledges it. If the next
//   byte of a partial frame does not arrive within TIMEOUT_CYC cycles, the
//   partial frame is discarded and timeout_err pulses for one cycle.
//
// Parameters
//   TIMEOUT_CYC  clk cycles allowed between bytes of one frame (>= 4)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   rx_rdy       receiver has a byte available (level, held until cleared)
//   rx_byte      received byte, valid while rx_rdy=1
//   clr_rdy      one-cycle pulse: byte consumed, receiver may clear rx_rdy
//   frm_vld      complete frame presented, held until frm_ack
//   frm_ack      decoder accepts the frame (ignored while frm_vld=0)
//   opcode       frame byte 0
//   data         {frame byte 1, frame byte 2}
//   timeout_err  one-cycle pulse: partial frame discarded on timeout
//   frm_cnt      number of frames accepted by the decoder, wraps 255 -> 0
// -----------------------------------------------------------------------------
module uart_frame_ctrl #(
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_byte,
   output logic        clr_rdy,
   output logic        frm_vld,
   input  logic        frm_ack,
   output logic [7:0]  opcode,
   output logic [15:0] data,
   output logic        timeout_err,
   output logic [7:0]  frm_cnt
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    idx, idx_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [7:0]    opcode_nx;
   logic [15:0]   data_nx;
   logic          frm_vld_nx;
   logic          timeout_nx;
   logic [7:0]    frm_cnt_nx;
   logic          cap;

   // clr_rdy high blocks capture for one cycle after each pulse, so a rx_rdy
   // that is slow to fall is not taken twice. While a frame is presented no
   // byte is taken, and the receiver keeps its byte until we return to IDLE.
   assign cap = rx_rdy & ~clr_rdy & (state != PRESENT);

   // NOTE: every signal assigned below gets a default value first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      tcnt_nx    = tcnt;
      opcode_nx  = opcode;
      data_nx    = data;
      frm_vld_nx = frm_vld;
      timeout_nx = 1'b0;
      frm_cnt_nx = frm_cnt;

      if (cap) begin
         case (idx)
            2'd0:    opcode_nx     = rx_byte;
            2'd1:    data_nx[15:8] = rx_byte;
            default: data_nx[7:0]  = rx_byte;
         endcase
         tcnt_nx = '0;
      end

      case (state)
         IDLE: begin
            idx_nx = 2'd0;
            if (cap) begin
               state_nx = COLLECT;
               idx_nx   = 2'd1;
            end
         end
         COLLECT: begin
            if (cap) begin
               // A byte arriving on the timeout cycle still counts: capture wins.
               if (idx == 2'd2) begin
                  state_nx   = PRESENT;
                  frm_vld_nx = 1'b1;
                  idx_nx     = 2'd0;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
               // Drop the partial frame. opcode/data keep stale bytes, but
               // frm_vld stays low, so they carry no meaning.
               state_nx   = IDLE;
               idx_nx     = 2'd0;
               tcnt_nx    = '0;
               timeout_nx = 1'b1;
            end else begin
               tcnt_nx = tcnt + TW'(1);
            end
         end
         PRESENT: begin
            if (frm_ack) begin
               state_nx   = IDLE;
               frm_vld_nx = 1'b0;
               frm_cnt_nx = frm_cnt + 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            tcnt_nx  = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments, so every flop here
   // samples its value from before the clock edge, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 2'd0;
         tcnt        <= '0;
         opcode      <= 8'd0;
         data        <= 16'd0;
         clr_rdy     <= 1'b0;
         frm_vld     <= 1'b0;
         timeout_err <= 1'b0;
         frm_cnt     <= 8'd0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         tcnt        <= tcnt_nx;
         opcode      <= opcode_nx;
         data        <= data_nx;
         clr_rdy     <= cap;
         frm_vld     <= frm_vld_nx;
         timeout_err <= timeout_nx;
         frm_cnt     <= frm_cnt_nx;
      end
   end

endmodule
